// File: rtl/uart_pkg.sv
// Shared types for the UART transmit scheduler: FSM state encoding and byte type.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } uart_sched_state_t;

    typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter signals of uart_tx_sched, plus debug taps of FSM state and pointer.
// Handshake: requester i holds req_valid[i]/req_data until a one-cycle req_ready[i] pulse accepts it.
interface uart_tx_sched_if #(parameter int N = 4);
    import uart_pkg::*;

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]      req_valid;
    logic [8*N-1:0]    req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    uart_byte_t        tx_data;
    logic              tx_start;
    logic              tx_cts;
    logic [N-1:0]      grant;
    logic              err_timeout;
    uart_sched_state_t dbg_state;
    logic [PW-1:0]     dbg_ptr;

    modport master (
        output req_valid, req_data, req_last, tx_cts,
        input  req_ready, tx_data, tx_start, grant, err_timeout, dbg_state, dbg_ptr
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_cts,
        output req_ready, tx_data, tx_start, grant, err_timeout, dbg_state, dbg_ptr
    );

endinterface

// File: rtl/uart_tx_sched_sync2.sv
// Generic two-flop synchronizer with a configurable reset value (synchronous active-low reset).
module sync2 #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = {W{1'b1}}
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among N byte requesters.
// Optional packet locking is enabled by defining UART_SCHED_LOCK_EN.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N       = 4,
    parameter int Timeout = 1048576
) (
    input  logic              clock,
    input  logic              reset,
    uart_tx_sched_if.slave    bus
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (Timeout > 1) ? $clog2(Timeout) : 1;
    localparam logic [CW-1:0] TMAX = CW'(Timeout - 1);

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input logic [PW-1:0] p);
        logic [N-1:0] oh;
        logic         found;
        oh    = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(p) + k) % N;
            if (!found && v[idx[PW-1:0]]) begin
                oh[idx[PW-1:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [PW-1:0] oh_index(input logic [N-1:0] oh);
        logic [PW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (oh[k]) r = PW'(k);
        end
        return r;
    endfunction

    logic              w_cts_s;
    uart_sched_state_t r_state, w_state_nxt;
    logic [PW-1:0]     r_ptr, w_ptr_nxt;
    logic [PW-1:0]     r_gidx, w_gidx_nxt;
    logic [N-1:0]      r_grant, w_grant_nxt;
    logic [N-1:0]      r_req_ready, w_req_ready_nxt;
    uart_byte_t        r_tx_data, w_tx_data_nxt;
    logic              r_tx_start, w_tx_start_nxt;
    logic              r_err, w_err_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [N-1:0]      w_elig_valid;
    logic [N-1:0]      w_pick;
    logic [PW-1:0]     w_pick_idx;
    logic [PW-1:0]     w_gidx_inc;
    uart_byte_t        w_pick_data;

    sync2 #(.W(1), .RST_VAL(1'b1)) u_cts_sync (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_d     (bus.tx_cts),
        .o_q     (w_cts_s)
    );

`ifdef UART_SCHED_LOCK_EN
    logic r_lock, w_lock_nxt;
    logic r_last, w_last_nxt;
    logic w_pick_last;

    // While locked, only the requester under the pointer may be granted.
    assign w_elig_valid = r_lock ? (bus.req_valid & (N'(1) << r_ptr)) : bus.req_valid;
`else
    logic w_unused_last;

    assign w_unused_last = ^bus.req_last;
    assign w_elig_valid  = bus.req_valid;
`endif

    assign w_pick     = rr_pick(w_elig_valid, r_ptr);
    assign w_pick_idx = oh_index(w_pick);
    assign w_gidx_inc = (r_gidx == PW'(N - 1)) ? '0 : r_gidx + PW'(1);

    always_comb begin
        w_pick_data = '0;
`ifdef UART_SCHED_LOCK_EN
        w_pick_last = 1'b0;
`endif
        for (int k = 0; k < N; k++) begin
            if (w_pick[k]) begin
                w_pick_data = bus.req_data[8*k +: 8];
`ifdef UART_SCHED_LOCK_EN
                w_pick_last = bus.req_last[k];
`endif
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gidx_nxt      = r_gidx;
        w_grant_nxt     = r_grant;
        w_req_ready_nxt = '0;
        w_tx_data_nxt   = r_tx_data;
        w_tx_start_nxt  = r_tx_start;
        w_err_nxt       = r_err;
        w_cnt_nxt       = r_cnt;
`ifdef UART_SCHED_LOCK_EN
        w_lock_nxt      = r_lock;
        w_last_nxt      = r_last;
`endif
        case (r_state)
            IDLE: begin
                if (w_cts_s && (|w_elig_valid)) begin
                    w_grant_nxt     = w_pick;
                    w_gidx_nxt      = w_pick_idx;
                    w_req_ready_nxt = w_pick;
                    w_tx_data_nxt   = w_pick_data;
`ifdef UART_SCHED_LOCK_EN
                    w_last_nxt      = w_pick_last;
`endif
                    w_state_nxt     = LOAD;
                end
            end
            LOAD: begin
                w_tx_start_nxt = 1'b1;
                w_cnt_nxt      = '0;
                w_state_nxt    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!w_cts_s) begin
                    w_tx_start_nxt = 1'b0;
                    w_state_nxt    = WAIT_DONE;
                end else if (r_cnt == TMAX) begin
                    // Transmitter never went busy: drop the accepted byte and flag it.
                    w_err_nxt      = 1'b1;
                    w_grant_nxt    = '0;
                    w_tx_start_nxt = 1'b0;
`ifdef UART_SCHED_LOCK_EN
                    w_lock_nxt     = 1'b0;
`endif
                    w_state_nxt    = IDLE;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (w_cts_s) begin
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
`ifdef UART_SCHED_LOCK_EN
                    if (!r_last) begin
                        w_ptr_nxt  = r_gidx;
                        w_lock_nxt = 1'b1;
                    end else begin
                        w_ptr_nxt  = w_gidx_inc;
                        w_lock_nxt = 1'b0;
                    end
`else
                    w_ptr_nxt   = w_gidx_inc;
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_grant     <= '0;
            r_req_ready <= '0;
            r_tx_data   <= 8'h00;
            r_tx_start  <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
`ifdef UART_SCHED_LOCK_EN
            r_lock      <= 1'b0;
            r_last      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gidx      <= w_gidx_nxt;
            r_grant     <= w_grant_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_err       <= w_err_nxt;
            r_cnt       <= w_cnt_nxt;
`ifdef UART_SCHED_LOCK_EN
            r_lock      <= w_lock_nxt;
            r_last      <= w_last_nxt;
`endif
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_start    = r_tx_start;
    assign bus.grant       = r_grant;
    assign bus.err_timeout = r_err;
    assign bus.dbg_state   = r_state;
    assign bus.dbg_ptr     = r_ptr;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter among `N` byte-stream requesters. Each requester offers bytes on a valid/ready handshake. The scheduler grants one requester, presents its byte to the transmitter, and holds the byte stable until the transmitter reports the frame complete. It then re-arbitrates. It sits between the system-clock producers (debug console, status reporter, etc.) and the baud-clocked UART TX, and handles the slow, asynchronous `cts` handshake so producers never see baud timing.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8.
- `Timeout`, 1048576: system clocks allowed for `tx_cts` to fall after a start before the frame is aborted.

Ports:
- `clock` input 1: system clock; the block's single clock.
- `reset` input 1: synchronous, active-low reset.
- `req_valid` input N: requester i has a byte.
- `req_data` input 8*N: byte of requester i in bits [8i+7:8i].
- `req_last` input N: last byte of a packet; used only with `UART_SCHED_LOCK_EN`.
- `req_ready` output N: one-hot pulse that accepts requester i's byte.
- `tx_data` output 8: byte to the transmitter.
- `tx_start` output 1: start/restart request to the transmitter (its `reptx`).
- `tx_cts` input 1: transmitter idle/done flag; asynchronous to `clock`.
- `grant` output N: one-hot owner of the current frame; 0 when idle.
- `err_timeout` output 1: sticky; set when a start is never acknowledged.

## Operation
- `tx_cts` passes through a 2-flop synchronizer before use; `cts_s` is the synchronized value.
- The FSM states are IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
- IDLE:
  - Entered when `cts_s`=1 and any `req_valid` is set.
  - Pick the first valid requester at or after pointer `ptr`, searching upward with modulo-N wrap.
  - Latch its byte into `tx_data`, set `grant`, pulse its `req_ready` for 1 cycle, then go to LOAD.
- LOAD: assert `tx_start`, load the timeout counter with 0, go to WAIT_BUSY.
- WAIT_BUSY:
  - `tx_start` stays high.
  - On `cts_s`=0, deassert `tx_start` and go to WAIT_DONE.
  - If the counter reaches `Timeout`-1 first, set `err_timeout`, clear `grant` and `tx_start`, and go to IDLE.
  - The byte is dropped on timeout; it was already accepted.
- WAIT_DONE: on `cts_s`=1, set `ptr` to (granted index + 1) mod N, clear `grant`, and go to IDLE.
- `tx_data` changes only in IDLE on a grant. It is stable from LOAD through WAIT_DONE, so the transmitter may latch it any time during the frame.
- Requesters that are not selected hold `req_valid`/`req_data`. Dropping `req_valid` before `req_ready` is legal and simply withdraws the request.
- The counter is `$clog2(Timeout)` bits and saturates; it does not wrap.
- If requesters assert simultaneously, the lowest index at or after `ptr` wins, so no requester waits more than N-1 frames.
- `req_valid` asserted while the transmitter is busy (`cts_s`=0 in IDLE) is not granted.

## Timing
- Reset values: `req_ready`=0, `tx_data`=8'h00, `tx_start`=0, `grant`=0, `err_timeout`=0, `ptr`=0, state IDLE, synchronizer flops 1.
- Latency:
  - Grant to `req_ready`: same cycle as the grant decision (registered, visible the next edge).
  - `req_ready` to `tx_start`: 1 clock.
  - `tx_cts` edge to `cts_s`: 2 clocks.
- Minimum gap between frames: 4 clocks plus the synchronizer delay, on top of the transmitter's own frame time.
- `err_timeout` clears only on reset.
- Reset mid-frame:
  - All outputs return to their reset values on the next edge.
  - `tx_start` falls, so the transmitter completes or idles by itself.
  - The next frame waits for `cts_s`=1.

## Configuration
- `UART_SCHED_LOCK_EN` defined:
  - A grant whose byte had `req_last`=0 is locked.
  - After WAIT_DONE, `ptr` stays on the granted index, and only that requester is eligible until a byte with `req_last`=1 completes or a timeout occurs.
  - Packets are never interleaved.
- Undefined: `req_last` is ignored and every byte re-arbitrates.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_sched_state_t` {IDLE, LOAD, WAIT_BUSY, WAIT_DONE}.
  - Byte typedef `uart_byte_t`.
- Sub-module `sync2`: generic 2-flop synchronizer with reset value parameter, reused for `tx_cts`.
- Round-robin pick is a function inside the block.

## Test plan
- Single requester 0 sends 8'hA5 (`Timeout` set small, e.g. 64):
  - `req_ready`[0] pulses once and `tx_data`=8'hA5 from that edge onward.
  - `tx_start` high until the model drops `cts`, then `grant` returns to 0 after `cts` rises.
- All 4 requesters valid continuously, starting from reset: grant order is 0,1,2,3,0.
  - Each receives exactly one `req_ready` per frame.
- Transmitter model holds `cts`=1 (never busy) with `Timeout`=64:
  - `err_timeout` rises exactly 64 clocks after `tx_start` rises, FSM back to IDLE, `tx_start`=0.
- `reset` driven low during WAIT_DONE: next edge shows all outputs at their reset values, `ptr`=0, and there is no `req_ready` until `cts_s`=1.
- `UART_SCHED_LOCK_EN`: requester 1 sends 3 bytes with `req_last` on the 3rd while requester 2 is valid.
  - Grant sequence 1,1,1,2.
  - Without the macro: 1,2,1,2,1.
- `cts` toggled 1 clock before a `req_valid` edge: no grant until the synchronized `cts` is 1, with `tx_data` stable across the whole frame.
